// File: rtl/fetch_unit_queued.sv
// Instruction fetch unit: credit-limited pipelined requests to instruction memory, returned
// instructions queued with their PCs for decode; redirects flush queued and in-flight work.
module fetch_unit_queued #(
   parameter int unsigned     XLEN          = 32,
   parameter int unsigned     ILEN          = 32,
   parameter logic [XLEN-1:0] PC_RESET_ADDR = '0,
   parameter int unsigned     FQ_DEPTH      = 4,
   parameter int unsigned     PC_STEP       = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] pc
);

   localparam int unsigned AW = $clog2(FQ_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0] pc_q;

   logic [XLEN-1:0] pend_pc_mem [FQ_DEPTH];
   logic [AW-1:0]   pend_wr_q;
   logic [AW-1:0]   pend_rd_q;

   logic [XLEN-1:0] oq_pc_mem    [FQ_DEPTH];
   logic [ILEN-1:0] oq_instr_mem [FQ_DEPTH];
   logic [AW-1:0]   oq_wr_q;
   logic [AW-1:0]   oq_rd_q;
   logic [CW-1:0]   oq_cnt_q;

   logic [CW-1:0]   outstanding_q;
   logic [CW-1:0]   drop_cnt_q;

   logic            credit_ok;
   logic            req_fire;
   logic            rsp_fire;
   logic            rsp_keep;
   logic            oq_pop;
   logic [CW-1:0]   outstanding_nxt;
   logic [XLEN-1:0] redirect_pc;

   // Handshake qualification; a redirect suppresses issue, queue push and queue pop.
   always_comb begin
      out_valid       = (oq_cnt_q != '0);
      credit_ok       = (SW'(outstanding_q) + SW'(oq_cnt_q)) < SW'(FQ_DEPTH);
      imem_req_valid  = rst_n && !redirect_valid && credit_ok;
      req_fire        = imem_req_valid && imem_req_ready;
      rsp_fire        = imem_rsp_valid && (outstanding_q != '0);
      rsp_keep        = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;
      oq_pop          = out_valid && out_ready && !redirect_valid;
      outstanding_nxt = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
      redirect_pc     = redirect_addr & ~XLEN'(3);
   end

   // Control state: PC, FIFO pointers and the in-flight / drop counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= PC_RESET_ADDR;
         pend_wr_q     <= '0;
         pend_rd_q     <= '0;
         oq_wr_q       <= '0;
         oq_rd_q       <= '0;
         oq_cnt_q      <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         outstanding_q <= outstanding_nxt;
         if (req_fire) begin
            pend_wr_q <= pend_wr_q + AW'(1);
         end
         if (rsp_fire) begin
            pend_rd_q <= pend_rd_q + AW'(1);
         end
         if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old path.
            pc_q       <= redirect_pc;
            oq_wr_q    <= '0;
            oq_rd_q    <= '0;
            oq_cnt_q   <= '0;
            drop_cnt_q <= outstanding_nxt;
         end else begin
            if (req_fire) begin
               pc_q <= pc_q + XLEN'(PC_STEP);
            end
            if (rsp_fire && (drop_cnt_q != '0)) begin
               drop_cnt_q <= drop_cnt_q - CW'(1);
            end
            if (rsp_keep) begin
               oq_wr_q <= oq_wr_q + AW'(1);
            end
            if (oq_pop) begin
               oq_rd_q <= oq_rd_q + AW'(1);
            end
            oq_cnt_q <= oq_cnt_q + CW'(rsp_keep) - CW'(oq_pop);
         end
      end
   end

   // Storage arrays carry no reset; validity is tracked by the pointers and counters.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         pend_pc_mem[pend_wr_q] <= pc_q;
      end
      if (rsp_keep) begin
         oq_pc_mem[oq_wr_q]    <= pend_pc_mem[pend_rd_q];
         oq_instr_mem[oq_wr_q] <= imem_rsp_data;
      end
   end

   always_comb begin
      imem_req_addr = pc_q;
      pc            = pc_q;
      out_pc        = out_valid ? oq_pc_mem[oq_rd_q] : '0;
      out_instr     = out_valid ? oq_instr_mem[oq_rd_q] : '0;
   end

endmodule

// File: tb/tb_fetch_unit_queued.sv
// Bench for fetch_unit_queued: a directed cycle table, corner-case sequences, and randomized
// traffic checked against a transaction-level model (in-flight queue tagged by redirect epoch).
`timescale 1ns/1ps
module tb_fetch_unit_queued;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] pc;

   always #5 clk = ~clk;

   fetch_unit_queued #(
      .XLEN(32), .ILEN(32), .PC_RESET_ADDR(32'h0000_0000), .FQ_DEPTH(DEPTH), .PC_STEP(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .pc(pc)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          rdy, ordy, rsp;
      logic [31:0] rsp_addr;
      bit          redir;
      logic [31:0] redir_addr;
      bit          e_rv;
      logic [31:0] e_ra;
      bit          e_ov;
      logic [31:0] e_opc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } oent_t;

   vec_t        tbl [25];
   mreq_t       mem_q [$];
   oent_t       exp_q [$];
   logic [31:0] dut_acc [$];
   logic [31:0] model_pc = '0;
   int unsigned epoch = 0;
   int unsigned cyc = 0;
   int unsigned last_due = 0;

   int unsigned p_rdy = 100, p_ordy = 100, p_redir = 0, p_spur = 0, lat_max = 1;
   bit          use_fixed = 1'b0;
   logic [31:0] fixed_addr = '0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
   endfunction

   function automatic vec_t mk(input int rdy, input int ordy, input int rsp, input logic [31:0] ra,
                               input int rv, input logic [31:0] rva, input int erv,
                               input logic [31:0] era, input int eov, input logic [31:0] eopc);
      vec_t v;
      v.rdy = (rdy != 0);  v.ordy = (ordy != 0);  v.rsp = (rsp != 0);  v.rsp_addr = ra;
      v.redir = (rv != 0); v.redir_addr = rva;
      v.e_rv = (erv != 0); v.e_ra = era; v.e_ov = (eov != 0); v.e_opc = eopc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Record every handshake the DUT actually completes.
   always @(posedge clk) begin
      if (rst_n && imem_req_valid && imem_req_ready) dut_acc.push_back(imem_req_addr);
   end

   task automatic do_reset();
      rst_n = 1'b0;
      imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0; redirect_addr = '0; imem_rsp_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      rst_n = 1'b1;
      mem_q.delete(); exp_q.delete(); dut_acc.delete();
      model_pc = 32'h0; epoch = 0; cyc = 0; last_due = 0;
   endtask

   // One cycle per iteration: drive after the edge, check at negedge, advance the model.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         logic        er;
         mreq_t       r;
         int unsigned d;
         imem_req_ready = ($urandom_range(99) < p_rdy);
         out_ready      = ($urandom_range(99) < p_ordy);
         redirect_valid = ($urandom_range(99) < p_redir);
         redirect_addr  = use_fixed ? fixed_addr : $urandom;
         if (mem_q.size() > 0) begin
            imem_rsp_valid = (mem_q[0].due <= cyc);
            imem_rsp_data  = data_of(mem_q[0].addr);
         end else begin
            imem_rsp_valid = ($urandom_range(99) < p_spur);
            imem_rsp_data  = $urandom;
         end
         @(negedge clk);
         er = !redirect_valid && ((mem_q.size() + exp_q.size()) < DEPTH);
         chk("req_valid", 32'(imem_req_valid), 32'(er));
         if (er) chk("req_addr", imem_req_addr, model_pc);
         chk("pc", pc, model_pc);
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", out_instr, exp_q[0].instr);
         end
         if (out_ready && !redirect_valid && exp_q.size() > 0) void'(exp_q.pop_front());
         if (imem_rsp_valid && mem_q.size() > 0) begin
            r = mem_q.pop_front();
            if (!redirect_valid && r.epoch == epoch) exp_q.push_back('{r.addr, data_of(r.addr)});
         end
         if (er && imem_req_ready) begin
            d = cyc + $urandom_range(lat_max, 1);
            if (d <= last_due) d = last_due + 1;
            mem_q.push_back('{model_pc, epoch, d});
            last_due = d;
            model_pc += 32'd4;
         end
         if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            model_pc = redirect_addr & ~32'd3;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      // rdy ordy rsp rsp_addr | redir redir_addr | exp req_valid/addr | exp out_valid/pc
      tbl[0]  = mk(1,1,0,32'h0,    0,32'h0,   1,32'h0,   0,32'h0);
      tbl[1]  = mk(1,1,1,32'h0,    0,32'h0,   1,32'h4,   0,32'h0);
      tbl[2]  = mk(1,1,1,32'h4,    0,32'h0,   1,32'h8,   1,32'h0);
      tbl[3]  = mk(1,1,1,32'h8,    0,32'h0,   1,32'hC,   1,32'h4);
      tbl[4]  = mk(0,1,1,32'hC,    0,32'h0,   1,32'h10,  1,32'h8);
      tbl[5]  = mk(0,1,0,32'h0,    0,32'h0,   1,32'h10,  1,32'hC);
      tbl[6]  = mk(0,1,0,32'h0,    0,32'h0,   1,32'h10,  0,32'h0);
      tbl[7]  = mk(1,1,0,32'h0,    0,32'h0,   1,32'h10,  0,32'h0);
      tbl[8]  = mk(1,1,0,32'h0,    0,32'h0,   1,32'h14,  0,32'h0);
      tbl[9]  = mk(1,1,0,32'h0,    1,32'h203, 0,32'h0,   0,32'h0);
      tbl[10] = mk(1,1,1,32'h10,   0,32'h0,   1,32'h200, 0,32'h0);
      tbl[11] = mk(1,1,1,32'h14,   0,32'h0,   1,32'h204, 0,32'h0);
      tbl[12] = mk(1,1,1,32'h200,  0,32'h0,   1,32'h208, 0,32'h0);
      tbl[13] = mk(1,1,1,32'h204,  0,32'h0,   1,32'h20C, 1,32'h200);
      tbl[14] = mk(1,1,1,32'h208,  1,32'h400, 0,32'h0,   1,32'h204);
      tbl[15] = mk(1,1,0,32'h0,    0,32'h0,   1,32'h400, 0,32'h0);
      tbl[16] = mk(1,1,1,32'h20C,  0,32'h0,   1,32'h404, 0,32'h0);
      tbl[17] = mk(1,1,1,32'h400,  0,32'h0,   1,32'h408, 0,32'h0);
      tbl[18] = mk(0,1,1,32'h404,  0,32'h0,   1,32'h40C, 1,32'h400);
      tbl[19] = mk(0,0,1,32'h408,  0,32'h0,   1,32'h40C, 1,32'h404);
      tbl[20] = mk(0,0,0,32'h0,    0,32'h0,   1,32'h40C, 1,32'h404);
      tbl[21] = mk(0,1,0,32'h0,    0,32'h0,   1,32'h40C, 1,32'h404);
      tbl[22] = mk(0,1,0,32'h0,    0,32'h0,   1,32'h40C, 1,32'h408);
      tbl[23] = mk(0,1,1,32'hDEAD0,0,32'h0,   1,32'h40C, 0,32'h0);
      tbl[24] = mk(0,1,0,32'h0,    0,32'h0,   1,32'h40C, 0,32'h0);

      do_reset();
      for (int i = 0; i < 25; i++) begin
         imem_req_ready = tbl[i].rdy;
         out_ready      = tbl[i].ordy;
         imem_rsp_valid = tbl[i].rsp;
         imem_rsp_data  = data_of(tbl[i].rsp_addr);
         redirect_valid = tbl[i].redir;
         redirect_addr  = tbl[i].redir_addr;
         @(negedge clk);
         chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
         if (tbl[i].e_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_ra);
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].e_opc);
            chk($sformatf("vec%0d_out_instr", i), out_instr, data_of(tbl[i].e_opc));
         end
         @(posedge clk);
         #1;
      end

      // Decode stalled: credits allow exactly DEPTH requests, then fetch resumes at 0x10.
      do_reset();
      p_rdy = 100; p_ordy = 0; p_redir = 0; p_spur = 0; lat_max = 1;
      run(10);
      chk("full_accept_count", 32'(dut_acc.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (dut_acc.size() > i) chk($sformatf("full_addr%0d", i), dut_acc[i], 32'(i * 4));
      end
      p_ordy = 100;
      run(4);
      chk("resume_seen", 32'(dut_acc.size() > 4), 32'd1);
      if (dut_acc.size() > 4) chk("resume_addr", dut_acc[4], 32'h10);

      // PC wrap at the top of the address space; redirect low bits are cleared.
      do_reset();
      p_rdy = 100; p_ordy = 100; p_redir = 100; use_fixed = 1'b1; fixed_addr = 32'hFFFF_FFFF;
      run(1);
      p_redir = 0; use_fixed = 1'b0;
      run(1);
      chk("wrap_pc", pc, 32'h0000_0000);
      run(6);

      // Asynchronous reset mid-stream with a backed-up queue, then stray responses.
      p_rdy = 100; p_ordy = 0; lat_max = 2;
      run(8);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_out_valid", 32'(out_valid), 32'h0);
      chk("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_q.delete(); exp_q.delete(); dut_acc.delete();
      model_pc = 32'h0; epoch = 0; cyc = 0; last_due = 0;
      p_rdy = 0; p_ordy = 100; p_spur = 100;
      run(3);
      p_spur = 0;

      // Randomized traffic with varying pressure, latency and redirect rate.
      for (int blk = 0; blk < 15; blk++) begin
         p_rdy   = $urandom_range(100, 30);
         p_ordy  = $urandom_range(100, 20);
         p_redir = $urandom_range(8, 0);
         p_spur  = $urandom_range(10, 0);
         lat_max = $urandom_range(4, 1);
         run(200);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
